// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that merges N_CH byte-stream requesters
// onto one TX FIFO write port. Each grant covers one burst, optionally led by
// a channel-ID header byte; bursts end on last, on MAX_BURST bytes, or when the
// owning channel sits idle for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int         WIDTH     = 8,
  parameter int         N_CH      = 4,
  parameter int         MAX_BURST = 16,
  parameter int         TIMEOUT   = 64,
  parameter int         HEADER_EN = 1,
  parameter logic [3:0] HDR_TAG   = 4'hA
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_CH-1:0]         req_valid_i,
  input  logic [N_CH*WIDTH-1:0]   req_data_i,
  input  logic [N_CH-1:0]         req_last_i,
  output logic [N_CH-1:0]         req_ready_o,
  output logic [WIDTH-1:0]        fifo_data_o,
  output logic                    fifo_wr_en_o,
  input  logic                    fifo_full_i,
  output logic [N_CH-1:0]         grant_o,
  output logic                    busy_o,
  output logic                    trunc_o
);

  localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t           state, state_nxt;
  logic [N_CH-1:0]  grant, grant_nxt;
  logic [IW-1:0]    gidx, gidx_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [BCW-1:0]   byte_cnt, byte_cnt_nxt;
  logic [ICW-1:0]   idle_cnt, idle_cnt_nxt;
  logic             trunc, trunc_nxt;

  logic [WIDTH-1:0] chan_data [N_CH];
  logic [IW-1:0]    win;
  logic             win_found;
  logic [IW-1:0]    gidx_inc;
  logic             accept, burst_end, idle_inc, timeout_hit;

  // Unpack the flat data bus into one byte per channel.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      chan_data[c] = req_data_i[c*WIDTH +: WIDTH];
    end
  end

  // Round-robin winner: first valid channel at or above ptr, wrapping around.
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!win_found && req_valid_i[c] && (c == (int'(ptr) + k) % N_CH)) begin
          win_found = 1'b1;
          win       = IW'(c);
        end
      end
    end
  end

  // Next-state and output decode; the data path is a zero-latency pass-through
  // so backpressure on the FIFO maps directly onto the granted channel's ready.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    gidx_nxt     = gidx;
    ptr_nxt      = ptr;
    byte_cnt_nxt = byte_cnt;
    idle_cnt_nxt = idle_cnt;
    trunc_nxt    = 1'b0;
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_data_o  = '0;
    accept       = 1'b0;
    burst_end    = 1'b0;
    idle_inc     = 1'b0;
    timeout_hit  = 1'b0;
    gidx_inc     = (gidx == IW'(N_CH - 1)) ? '0 : gidx + IW'(1);

    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt    = N_CH'(1) << win;
          gidx_nxt     = win;
          byte_cnt_nxt = '0;
          idle_cnt_nxt = '0;
          state_nxt    = (HEADER_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        fifo_wr_en_o = !fifo_full_i;
        fifo_data_o  = WIDTH'({HDR_TAG, 4'(gidx)});
        if (!fifo_full_i) state_nxt = DATA;
      end
      DATA: begin
        req_ready_o[gidx] = !fifo_full_i;
        fifo_data_o       = chan_data[gidx];
        accept            = req_valid_i[gidx] && !fifo_full_i;
        fifo_wr_en_o      = accept;
        // Idle time only accrues while the FIFO could have taken a byte.
        idle_inc          = !req_valid_i[gidx] && !fifo_full_i;
        timeout_hit       = idle_inc && (idle_cnt == ICW'(TIMEOUT - 1));
        if (accept) begin
          byte_cnt_nxt = byte_cnt + BCW'(1);
          idle_cnt_nxt = '0;
          burst_end    = req_last_i[gidx] || (byte_cnt == BCW'(MAX_BURST - 1));
        end else if (req_valid_i[gidx]) begin
          idle_cnt_nxt = '0;
        end else if (idle_inc) begin
          idle_cnt_nxt = idle_cnt + ICW'(1);
        end
        if (burst_end || timeout_hit) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = gidx_inc;
          trunc_nxt = timeout_hit;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and control registers; reset aborts any burst in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      ptr      <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      trunc    <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      gidx     <= gidx_nxt;
      ptr      <= ptr_nxt;
      byte_cnt <= byte_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      trunc    <= trunc_nxt;
    end
  end

  assign grant_o = grant;
  assign busy_o  = (state != IDLE);
  assign trunc_o = trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: per-channel byte sources feed the arbiter; every expected
// FIFO byte is queued when a burst is loaded and popped as the DUT writes it.
module tb_uart_tx_arbiter;

  localparam int N_CH = 4;
  localparam int W    = 8;

  typedef logic [8:0] ent_t;  // {last, data}

  typedef struct {
    int         ch;
    int         nbytes;
    logic [7:0] base;
    logic [7:0] step;
    int         exp_wr;
    int         exp_gcyc;
    int         exp_cyc;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic [N_CH-1:0]       req_valid;
  logic [N_CH*W-1:0]     req_data;
  logic [N_CH-1:0]       req_last;
  logic [N_CH-1:0]       req_ready;
  logic [W-1:0]          fifo_data;
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic [N_CH-1:0]       grant;
  logic                  busy;
  logic                  trunc;

  int         total = 0;
  int         bad   = 0;
  ent_t       src_q [N_CH][$];
  logic [7:0] exp_q [$];
  int         nwrites, ntrunc, gcnt, cyc, wcyc, tcyc, ncyc;
  logic [3:0] gwatch, grant_at_trunc;
  bit         stall_chk;
  vec_t       vecs [5];

  uart_tx_arbiter #(
    .WIDTH(8), .N_CH(N_CH), .MAX_BURST(16), .TIMEOUT(64), .HEADER_EN(1), .HDR_TAG(4'hA)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .fifo_data_o(fifo_data), .fifo_wr_en_o(fifo_wr_en), .fifo_full_i(fifo_full),
    .grant_o(grant), .busy_o(busy), .trunc_o(trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N_CH; c++) begin
      if (src_q[c].size() > 0) begin
        ent_t h;
        h = src_q[c][0];
        req_valid[c]        = 1'b1;
        req_data[c*W +: W]  = h[7:0];
        req_last[c]         = h[8];
      end else begin
        req_valid[c]        = 1'b0;
        req_data[c*W +: W]  = '0;
        req_last[c]         = 1'b0;
      end
    end
  endtask

  function automatic bit srcs_empty();
    for (int c = 0; c < N_CH; c++) if (src_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_src(input int ch, input int n, input logic [7:0] base,
                          input logic [7:0] step, input bit last_end);
    for (int i = 0; i < n; i++) begin
      ent_t e;
      e[7:0] = base + 8'(i) * step;
      e[8]   = last_end && (i == n - 1);
      src_q[ch].push_back(e);
    end
  endtask

  task automatic exp_burst(input int ch, input int n, input logic [7:0] base, input logic [7:0] step);
    exp_q.push_back({4'hA, 4'(ch)});
    for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i) * step);
  endtask

  // One clock: observe mid-cycle, then advance and re-drive the sources.
  task automatic tick();
    logic [N_CH-1:0] take;
    @(negedge clk);
    if (fifo_wr_en) begin
      nwrites++;
      wcyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fifo_unexpected: wrote %0h with nothing expected", fifo_data);
      end else begin
        chk("fifo_data", fifo_data, exp_q.pop_front());
      end
    end
    if (trunc) begin
      ntrunc++;
      tcyc = cyc;
      grant_at_trunc = grant;
    end
    if (grant == gwatch) gcnt++;
    if (stall_chk) begin
      chk("stall_wr_en", fifo_wr_en, 0);
      chk("stall_ready", req_ready, 0);
    end
    take = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) if (take[c]) void'(src_q[c].pop_front());
    drive();
    cyc++;
  endtask

  task automatic run_quiet(input string nm, input int budget, output int n);
    bit done = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      if (!busy && srcs_empty()) done = 1'b1;
    end
    chk(nm, done, 1);
  endtask

  task automatic clear_counts();
    nwrites = 0; ntrunc = 0; gcnt = 0; stall_chk = 1'b0; gwatch = 4'hF;
  endtask

  initial begin
    vecs[0] = '{2, 3,  8'h11, 8'h11, 4,  4,  5};
    vecs[1] = '{0, 1,  8'h5A, 8'h01, 2,  2,  3};
    vecs[2] = '{1, 16, 8'h40, 8'h01, 17, 17, 18};
    vecs[3] = '{2, 5,  8'hC0, 8'h03, 6,  6,  7};
    vecs[4] = '{3, 2,  8'hF0, 8'h01, 3,  3,  4};

    cyc = 0; wcyc = 0; tcyc = 0;
    clear_counts();
    fifo_full = 1'b0;
    reset_i   = 1'b0;
    drive();
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", fifo_data, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;

    // Single-channel bursts from the table.
    foreach (vecs[i]) begin
      clear_counts();
      gwatch = 4'(1 << vecs[i].ch);
      exp_burst(vecs[i].ch, vecs[i].nbytes, vecs[i].base, vecs[i].step);
      load_src(vecs[i].ch, vecs[i].nbytes, vecs[i].base, vecs[i].step, 1'b1);
      drive();
      run_quiet("vec_bound", 100, ncyc);
      chk("vec_writes", nwrites, vecs[i].exp_wr);
      chk("vec_grant_cycles", gcnt, vecs[i].exp_gcyc);
      chk("vec_cycles", ncyc, vecs[i].exp_cyc);
      chk("vec_no_trunc", ntrunc, 0);
      chk("vec_exp_left", exp_q.size(), 0);
      chk("vec_grant_idle", grant, 0);
    end

    // All four channels, one byte each: order 0,1,2,3 with one bubble between.
    clear_counts();
    for (int c = 0; c < N_CH; c++) begin
      exp_burst(c, 1, 8'hD0 + 8'(c), 8'h00);
      load_src(c, 1, 8'hD0 + 8'(c), 8'h00, 1'b1);
    end
    drive();
    run_quiet("all_bound", 100, ncyc);
    chk("all_cycles", ncyc, 12);
    chk("all_writes", nwrites, 8);
    chk("all_exp_left", exp_q.size(), 0);
    // Pointer wrapped back to 0: ch0 beats ch3.
    clear_counts();
    exp_burst(0, 1, 8'h01, 8'h00);
    exp_burst(3, 1, 8'h03, 8'h00);
    load_src(0, 1, 8'h01, 8'h00, 1'b1);
    load_src(3, 1, 8'h03, 8'h00, 1'b1);
    drive();
    tick();
    tick();
    chk("wrap_first_grant", grant, 4'b0001);
    run_quiet("wrap_bound", 100, ncyc);
    chk("wrap_exp_left", exp_q.size(), 0);

    // Backpressure mid-burst on ch0 for 10 cycles.
    clear_counts();
    exp_burst(0, 6, 8'h60, 8'h01);
    load_src(0, 6, 8'h60, 8'h01, 1'b1);
    drive();
    tick(); tick(); tick();
    fifo_full = 1'b1;
    stall_chk = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    fifo_full = 1'b0;
    stall_chk = 1'b0;
    run_quiet("stall_bound", 100, ncyc);
    chk("stall_writes", nwrites, 7);
    chk("stall_no_trunc", ntrunc, 0);
    chk("stall_exp_left", exp_q.size(), 0);

    // ch1 streams 20 bytes with no last: split at 16, re-headered, then timeout.
    clear_counts();
    exp_burst(1, 16, 8'h00, 8'h01);
    exp_burst(1, 4, 8'h10, 8'h01);
    load_src(1, 20, 8'h00, 8'h01, 1'b0);
    drive();
    run_quiet("maxb_bound", 200, ncyc);
    tick(); tick(); tick();
    chk("maxb_writes", nwrites, 22);
    chk("maxb_trunc", ntrunc, 1);
    chk("maxb_exp_left", exp_q.size(), 0);

    // ch3 sends one byte then goes quiet. Byte accepted at the edge closing
    // cycle X; 64 idle cycles X+1..X+64 release it, trunc_o shows in X+65.
    clear_counts();
    exp_burst(3, 1, 8'h77, 8'h00);
    load_src(3, 1, 8'h77, 8'h00, 1'b0);
    drive();
    run_quiet("tmo_bound", 200, ncyc);
    tick(); tick();
    chk("tmo_trunc_count", ntrunc, 1);
    chk("tmo_delay", tcyc - wcyc, 65);
    chk("tmo_grant_at_trunc", grant_at_trunc, 0);
    // Pointer advanced past ch3 to 0.
    clear_counts();
    exp_burst(0, 1, 8'h81, 8'h00);
    exp_burst(3, 1, 8'h83, 8'h00);
    load_src(0, 1, 8'h81, 8'h00, 1'b1);
    load_src(3, 1, 8'h83, 8'h00, 1'b1);
    drive();
    tick();
    chk("tmo_ptr_grant", grant, 4'b0001);
    run_quiet("tmo_ptr_bound", 100, ncyc);
    chk("tmo_ptr_exp_left", exp_q.size(), 0);

    // Asynchronous reset in the middle of a ch1 burst.
    clear_counts();
    exp_burst(1, 8, 8'h90, 8'h01);
    load_src(1, 8, 8'h90, 8'h01, 1'b1);
    drive();
    tick(); tick(); tick(); tick();
    chk("mid_grant", grant, 4'b0010);
    #2;
    reset_i = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wr_en", fifo_wr_en, 0);
    for (int c = 0; c < N_CH; c++) src_q[c].delete();
    exp_q.delete();
    drive();
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    clear_counts();
    exp_burst(0, 1, 8'hB0, 8'h00);
    exp_burst(3, 1, 8'hB3, 8'h00);
    load_src(0, 1, 8'hB0, 8'h00, 1'b1);
    load_src(3, 1, 8'hB3, 8'h00, 1'b1);
    drive();
    tick();
    chk("arst_first_grant", grant, 4'b0001);
    run_quiet("arst_bound", 100, ncyc);
    chk("arst_exp_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
